clk_div_meter: RTL and testbench

Measures the divide ratio and duty cycle of a slow clock-like signal, sampled in the fast clock domain. Intended for on-chip checking of the team's integer and odd clock dividers, with 50% duty odd division the primary target. It is the measuring end of the divider: it takes the divided clock back in and reports high-phase length, low-phase length, total period and a 50%-duty flag, all counted in clk_in cycles. sig_in is treated as asynchronous data, never as a clock.

---
 rtl/clk_div_meter.sv | 141 ++++++++++++++
 tb/tb_clk_div_meter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_meter.sv
// clk_div_meter: measures the high phase, low phase, period and duty-cycle balance of a
// slow clock-like signal. The signal is sampled as asynchronous data in the clk_in
// domain. All results are counted in clk_in cycles.
module clk_div_meter #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] high_len,
  output logic [CNT_W-1:0] low_len,
  output logic [CNT_W:0]   period,
  output logic             duty50,
  output logic             meas_valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StWaitRise, StHigh, StLow} state_e;

  state_e                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_prev;
  logic [CNT_W-1:0]       r_hcnt;
  logic [CNT_W-1:0]       r_lcnt;
  logic [CNT_W-1:0]       r_h_lat;
  logic [CNT_W-1:0]       r_high_len;
  logic [CNT_W-1:0]       r_low_len;
  logic [CNT_W:0]         r_period;
  logic                   r_duty50;
  logic                   r_meas_valid;
  logic                   r_timeout;

  logic                   w_s_sync;
  logic                   w_rise;
  logic                   w_fall;
  logic [CNT_W:0]         w_period;
  logic [CNT_W-1:0]       w_diff;
  logic                   w_duty50;

  assign w_s_sync = r_sync[SYNC_STAGES-1];
  assign w_rise   = w_s_sync & ~r_s_prev;
  assign w_fall   = ~w_s_sync & r_s_prev;

  // Results of the period closing on this rise; one extra bit so the sum never wraps.
  assign w_period = {1'b0, r_h_lat} + {1'b0, r_lcnt};
  assign w_diff   = (r_h_lat >= r_lcnt) ? (r_h_lat - r_lcnt) : (r_lcnt - r_h_lat);
  assign w_duty50 = (w_diff[CNT_W-1:1] == '0);

  // Synchronize sig_in and keep the previous synchronized value for edge detection.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_sync   <= '0;
      r_s_prev <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], sig_in};
      r_s_prev <= w_s_sync;
    end
  end

  // Phase-measurement FSM with registered results, valid pulse and sticky timeout.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_state      <= StIdle;
      r_hcnt       <= '0;
      r_lcnt       <= '0;
      r_h_lat      <= '0;
      r_high_len   <= '0;
      r_low_len    <= '0;
      r_period     <= '0;
      r_duty50     <= 1'b0;
      r_meas_valid <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_meas_valid <= 1'b0;
      if (!en) begin
        // Results and timeout hold; any partial measurement is abandoned.
        r_state <= StIdle;
        r_hcnt  <= '0;
        r_lcnt  <= '0;
      end else begin
        unique case (r_state)
          StIdle: begin
            r_hcnt  <= '0;
            r_lcnt  <= '0;
            r_state <= StWaitRise;
          end
          StWaitRise: begin
            if (w_rise) begin
              r_hcnt  <= CntOne;
              r_state <= StHigh;
            end
          end
          StHigh: begin
            if (w_fall) begin
              r_h_lat <= r_hcnt;
              r_lcnt  <= CntOne;
              r_state <= StLow;
            end else if (r_hcnt == CntMax) begin
              r_timeout <= 1'b1;
              r_state   <= StWaitRise;
            end else begin
              r_hcnt <= r_hcnt + CntOne;
            end
          end
          StLow: begin
            if (w_rise) begin
              // Close this period and start the next high phase with no gap.
              r_high_len   <= r_h_lat;
              r_low_len    <= r_lcnt;
              r_period     <= w_period;
              r_duty50     <= w_duty50;
              r_meas_valid <= 1'b1;
              r_timeout    <= 1'b0;
              r_hcnt       <= CntOne;
              r_state      <= StHigh;
            end else if (r_lcnt == CntMax) begin
              r_timeout <= 1'b1;
              r_state   <= StWaitRise;
            end else begin
              r_lcnt <= r_lcnt + CntOne;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign high_len   = r_high_len;
  assign low_len    = r_low_len;
  assign period     = r_period;
  assign duty50     = r_duty50;
  assign meas_valid = r_meas_valid;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_clk_div_meter.sv
// Directed bench for clk_div_meter: stimulus pushes expected periods into a queue, a
// negedge monitor pops one entry per meas_valid and compares every result field.
module tb_clk_div_meter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       sig_in;
  logic [7:0] high_len;
  logic [7:0] low_len;
  logic [8:0] period;
  logic       duty50;
  logic       meas_valid;
  logic       timeout;

  typedef struct {
    int h;
    int l;
    int gap;    // expected cycles since previous meas_valid, 0 = unchecked
    bit loose;  // dual-edge source: high in {7,8}, sum 15
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_cyc = 0;

  clk_div_meter #(
    .CNT_W      (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk_in    (clk),
    .rst       (rst_n),
    .en        (en),
    .sig_in    (sig_in),
    .high_len  (high_len),
    .low_len   (low_len),
    .period    (period),
    .duty50    (duty50),
    .meas_valid(meas_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp_v);
    n_checks = n_checks + 1;
    assert (obs === exp_v) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Advance n clocks and leave inputs changing 1 time unit after the rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int h, input int l, input int gap, input bit loose);
    exp_t e;
    e.h     = h;
    e.l     = l;
    e.gap   = gap;
    e.loose = loose;
    q.push_back(e);
  endtask

  task automatic drive_period(input int h, input int l, input bit gapchk);
    push_exp(h, l, gapchk ? (h + l) : 0, 1'b0);
    sig_in = 1'b1;
    step(h);
    sig_in = 1'b0;
    step(l);
  endtask

  // 50% duty divide-by-15 built from both clock edges: 7.5 cycles high, 7.5 low.
  task automatic drive_dual(input bit gapchk);
    push_exp(0, 0, gapchk ? 15 : 0, 1'b1);
    sig_in = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    #1;
    sig_in = 1'b0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_high_len"}, high_len, 0);
    check({tag, "_low_len"}, low_len, 0);
    check({tag, "_period"}, period, 0);
    check({tag, "_duty50"}, duty50, 0);
    check({tag, "_meas_valid"}, meas_valid, 0);
    check({tag, "_timeout"}, timeout, 0);
  endtask

  // Scoreboard: every meas_valid must match the oldest outstanding expected period.
  always @(negedge clk) begin
    if (rst_n && meas_valid) begin
      exp_t e;
      int   d;
      check("valid_expected", int'(q.size() != 0), 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        if (e.loose) begin
          check("dual_period", period, 15);
          check("dual_high_7_or_8", int'(high_len == 8'd7 || high_len == 8'd8), 1);
          check("dual_sum", int'(high_len) + int'(low_len), 15);
          check("dual_duty50", duty50, 1);
        end else begin
          d = e.h - e.l;
          check("high_len", high_len, e.h);
          check("low_len", low_len, e.l);
          check("period", period, e.h + e.l);
          check("duty50", duty50, int'(d <= 1 && d >= -1));
        end
        check("timeout_at_valid", timeout, 0);
        if (e.gap != 0) check("valid_spacing", cyc - last_cyc, e.gap);
      end
      last_cyc = cyc;
    end
  end

  initial begin
    bit seen;
    rst_n  = 1'b0;
    en     = 1'b0;
    sig_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    step(2);
    en = 1'b1;
    step(3);

    // Divide-by-15, 8 high / 7 low.
    drive_period(8, 7, 1'b0);
    repeat (3) drive_period(8, 7, 1'b1);

    // Divide-by-4, 1 high / 3 low.
    repeat (4) drive_period(1, 3, 1'b1);

    // Odd dual-edge divide-by-15.
    repeat (4) drive_dual(1'b1);

    // Hold high until the high counter saturates.
    sig_in = 1'b1;
    seen   = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (meas_valid) seen = 1'b1;
    end
    check("sat_wait_valid", seen, 1);
    repeat (254) @(posedge clk);
    @(negedge clk);
    check("sat_not_yet_at_255", timeout, 0);
    @(posedge clk);
    @(negedge clk);
    check("sat_timeout", timeout, 1);
    check("sat_no_valid", meas_valid, 0);
    check("sat_hold_high_len", high_len, 7);
    check("sat_hold_low_len", low_len, 8);
    check("sat_hold_period", period, 15);
    check("sat_hold_duty50", duty50, 1);
    @(posedge clk);
    #1;
    sig_in = 1'b0;
    step(4);
    check("sat_timeout_sticky", timeout, 1);
    drive_period(6, 4, 1'b0);
    repeat (2) drive_period(6, 4, 1'b1);

    // Drop enable for 5 cycles in the middle of a high phase.
    sig_in = 1'b1;
    step(3);
    en = 1'b0;
    step(5);
    check("en_off_no_valid", meas_valid, 0);
    check("en_off_high_len", high_len, 6);
    check("en_off_low_len", low_len, 4);
    check("en_off_period", period, 10);
    check("en_off_duty50", duty50, 0);
    check("en_off_timeout", timeout, 0);
    en = 1'b1;
    step(2);
    sig_in = 1'b0;
    step(4);
    drive_period(4, 6, 1'b0);
    drive_period(4, 6, 1'b1);

    // Asynchronous reset in the middle of a low phase.
    drive_period(5, 5, 1'b1);
    sig_in = 1'b1;
    step(5);
    sig_in = 1'b0;
    step(3);
    check("pre_rst_period", period, 10);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(3);
    drive_period(5, 5, 1'b0);
    drive_period(3, 2, 1'b1);

    // Closing rise reports the last period; then the queue must be empty.
    sig_in = 1'b1;
    step(4);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
